// File: rtl/cache_ctrl_dm_pkg.sv
// Shared definitions for the direct-mapped cache controller.
// Bus/CPU request encodings, error codes, widths and the controller state type.
package cache_ctrl_dm_pkg;

  localparam int unsigned IOSTATEWIDTH = 2;
  localparam int unsigned ADDRWIDTH    = 16;
  localparam int unsigned WORDWIDTH    = 16;
  localparam int unsigned ERRWIDTH     = 2;

  // Request encodings shared by the CPU port and memBus; 2'b11 is illegal.
  localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
  localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
  localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

  localparam logic [ERRWIDTH-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERRWIDTH-1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [ERRWIDTH-1:0] ERR_BADRW   = 2'd2;

  typedef enum logic [1:0] {
    CsIdle     = 2'd0,
    CsWbWait   = 2'd1,
    CsFillWait = 2'd2,
    CsResp     = 2'd3
  } cache_state_e;

endpackage

// File: rtl/cache_ctrl_dm_bus_hs.sv
// Bus handshake tracker shared by both wait states of the cache controller.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   start       pulse on entry to a wait state: clears busy flag and counter
//   active      high while a wait state is occupied
//   ack         bus acknowledge (low = busy/not granted, high = idle/done)
//   done        completion: ack high after it has been seen low
//   timeout     transaction has been open for TIMEOUT wait cycles
module cache_bus_hs #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic done,
  output logic timeout
);

  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  logic            seen_busy_q;
  logic [CNTW-1:0] cnt_q;

  // Ack high before the bus has gone busy means the request was not yet accepted.
  assign done    = active && seen_busy_q && ack;
  assign timeout = active && !done && (cnt_q == CNTW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_busy_q <= 1'b0;
      cnt_q       <= '0;
    end else if (start) begin
      seen_busy_q <= 1'b0;
      cnt_q       <= '0;
    end else if (active) begin
      if (!ack) begin
        seen_busy_q <= 1'b1;
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-back, write-allocate cache between a CPU port and one memBus requester.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   cpuRw, cpuAddr, cpuWdata         CPU request, held until cpuReady
//   cpuRdata, cpuReady               read data and one-cycle completion pulse
//   rwToBus, addrToBus, dataToBus    bus request (writeback or fill)
//   dataFromBus                      fill data
//   rdEnFromBus, wbDoneFromBus       read / write acknowledges
//   errReg                           sticky error code
module cache_ctrl_dm
  import cache_ctrl_dm_pkg::*;
#(
  parameter int unsigned LINES   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] cpuRw,
  input  logic [ADDRWIDTH-1:0]    cpuAddr,
  input  logic [WORDWIDTH-1:0]    cpuWdata,
  output logic [WORDWIDTH-1:0]    cpuRdata,
  output logic                    cpuReady,
  output logic [IOSTATEWIDTH-1:0] rwToBus,
  output logic [ADDRWIDTH-1:0]    addrToBus,
  output logic [WORDWIDTH-1:0]    dataToBus,
  input  logic [WORDWIDTH-1:0]    dataFromBus,
  input  logic                    rdEnFromBus,
  input  logic                    wbDoneFromBus,
  output logic [ERRWIDTH-1:0]     errReg
);

  localparam int unsigned IDXW = $clog2(LINES);
  localparam int unsigned TAGW = ADDRWIDTH - IDXW;

  cache_state_e state_q, state_d;

  logic [TAGW-1:0]      tag_q  [LINES];
  logic [WORDWIDTH-1:0] line_q [LINES];
  logic [LINES-1:0]     valid_q, dirty_q;

  logic [IOSTATEWIDTH-1:0] bus_rw_q, bus_rw_d;
  logic [ADDRWIDTH-1:0]    bus_addr_q, bus_addr_d;
  logic [WORDWIDTH-1:0]    bus_data_q, bus_data_d;
  logic [WORDWIDTH-1:0]    rdata_q, rdata_d;
  logic [ERRWIDTH-1:0]     err_q, err_d;

  logic                 wr_en, wr_dirty, clr_dirty;
  logic [WORDWIDTH-1:0] wr_data;
  logic                 hs_start, hs_active, hs_ack, hs_done, hs_timeout;

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            req_ok, hit, victim_dirty;

  assign idx          = cpuAddr[IDXW-1:0];
  assign tag          = cpuAddr[ADDRWIDTH-1:IDXW];
  assign req_ok       = (cpuRw == RD) || (cpuRw == WT);
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  assign hs_active = (state_q == CsWbWait) || (state_q == CsFillWait);
  assign hs_ack    = (state_q == CsWbWait) ? wbDoneFromBus : rdEnFromBus;

  cache_bus_hs #(
    .TIMEOUT(TIMEOUT)
  ) u_bus_hs (
    .clk    (clk),
    .reset  (reset),
    .start  (hs_start),
    .active (hs_active),
    .ack    (hs_ack),
    .done   (hs_done),
    .timeout(hs_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CsIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CsIdle: begin
        if (cpuRw != IDEL) begin
          if (!req_ok || hit)              state_d = CsResp;
          else if (victim_dirty)           state_d = CsWbWait;
          else if (cpuRw == WT)            state_d = CsResp;
          else                             state_d = CsFillWait;
        end
      end
      CsWbWait: begin
        if (hs_done)         state_d = (cpuRw == RD) ? CsFillWait : CsResp;
        else if (hs_timeout) state_d = CsResp;
      end
      CsFillWait: begin
        if (hs_done || hs_timeout) state_d = CsResp;
      end
      CsResp:  state_d = CsIdle;
      default: state_d = CsIdle;
    endcase
  end

  always_comb begin
    bus_rw_d   = bus_rw_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    hs_start   = 1'b0;
    wr_en      = 1'b0;
    wr_dirty   = 1'b0;
    wr_data    = cpuWdata;
    clr_dirty  = 1'b0;
    unique case (state_q)
      CsIdle: begin
        if (req_ok) begin
          if (hit) begin
            if (cpuRw == RD) begin
              rdata_d = line_q[idx];
            end else begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
            end
          end else if (victim_dirty) begin
            bus_rw_d   = WT;
            bus_addr_d = {tag_q[idx], idx};
            bus_data_d = line_q[idx];
            hs_start   = 1'b1;
          end else if (cpuRw == WT) begin
            // Whole-word write to a clean line needs no fill.
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
          end else begin
            bus_rw_d   = RD;
            bus_addr_d = cpuAddr;
            hs_start   = 1'b1;
          end
        end else if (cpuRw != IDEL) begin
          err_d   = ERR_BADRW;
          rdata_d = '0;
        end
      end
      CsWbWait: begin
        if (hs_done) begin
          clr_dirty = 1'b1;
          bus_rw_d  = IDEL;
          if (cpuRw == RD) begin
            bus_rw_d   = RD;
            bus_addr_d = cpuAddr;
            hs_start   = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
          end
        end else if (hs_timeout) begin
          bus_rw_d = IDEL;
          err_d    = ERR_TIMEOUT;
          rdata_d  = '0;
        end
      end
      CsFillWait: begin
        if (hs_done) begin
          bus_rw_d = IDEL;
          wr_en    = 1'b1;
          wr_data  = dataFromBus;
          rdata_d  = dataFromBus;
        end else if (hs_timeout) begin
          bus_rw_d = IDEL;
          err_d    = ERR_TIMEOUT;
          rdata_d  = '0;
        end
      end
      CsResp:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_rw_q   <= IDEL;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      rdata_q    <= '0;
      err_q      <= ERR_NONE;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      bus_rw_q   <= bus_rw_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      if (clr_dirty) begin
        dirty_q[idx] <= 1'b0;
      end
      // A write-miss install after writeback overrides the dirty clear.
      if (wr_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= wr_dirty;
      end
    end
  end

  // Tag and data storage need no reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx]  <= tag;
      line_q[idx] <= wr_data;
    end
  end

  assign cpuReady  = (state_q == CsResp);
  assign cpuRdata  = rdata_q;
  assign rwToBus   = bus_rw_q;
  assign addrToBus = bus_addr_q;
  assign dataToBus = bus_data_q;
  assign errReg    = err_q;

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Self-checking bench for cache_ctrl_dm: a memBus responder plus a line-level cache model.
module tb_cache_ctrl_dm;
  import cache_ctrl_dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpuRw;
  logic [15:0] cpuAddr, cpuWdata, cpuRdata;
  logic        cpuReady;
  logic [1:0]  rwToBus;
  logic [15:0] addrToBus, dataToBus, dataFromBus;
  logic        rdEnFromBus, wbDoneFromBus;
  logic [1:0]  errReg;

  cache_ctrl_dm #(
    .LINES  (16),
    .TIMEOUT(1023)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpuRw        (cpuRw),
    .cpuAddr      (cpuAddr),
    .cpuWdata     (cpuWdata),
    .cpuRdata     (cpuRdata),
    .cpuReady     (cpuReady),
    .rwToBus      (rwToBus),
    .addrToBus    (addrToBus),
    .dataToBus    (dataToBus),
    .dataFromBus  (dataFromBus),
    .rdEnFromBus  (rdEnFromBus),
    .wbDoneFromBus(wbDoneFromBus),
    .errReg       (errReg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Environment memory behind the bus, and the model's own view of memory.
  logic [15:0] bus_mem [65536];
  logic [15:0] ref_mem [65536];

  int log_rw[$], log_addr[$], log_data[$];
  int exp_rw[$], exp_addr[$], exp_data[$];

  int pre_delay = 1;  // cycles ack stays high after a request
  int busy      = 100;  // cycles ack stays low
  int phase = 0, cnt = 0, cur_rw = 0, cur_addr = 0, cur_data = 0;

  task automatic start_txn();
    cur_rw   = int'(rwToBus);
    cur_addr = int'(addrToBus);
    cur_data = int'(dataToBus);
    log_rw.push_back(cur_rw);
    log_addr.push_back(cur_addr);
    log_data.push_back(cur_data);
    if (rwToBus == RD) dataFromBus = bus_mem[cur_addr];
    cnt   = 0;
    phase = 1;
  endtask

  // memBus responder, acting on the falling edge.
  initial begin
    rdEnFromBus   = 1'b1;
    wbDoneFromBus = 1'b1;
    dataFromBus   = '0;
    forever begin
      @(negedge clk);
      if (rwToBus == IDEL) begin
        phase         = 0;
        rdEnFromBus   = 1'b1;
        wbDoneFromBus = 1'b1;
      end else if (phase == 0 || phase == 3) begin
        start_txn();
      end else if (phase == 1) begin
        cnt++;
        if (cnt >= pre_delay) begin
          if (cur_rw == int'(RD)) rdEnFromBus = 1'b0;
          else wbDoneFromBus = 1'b0;
          cnt   = 0;
          phase = 2;
        end
      end else begin
        cnt++;
        if (cnt >= busy) begin
          rdEnFromBus   = 1'b1;
          wbDoneFromBus = 1'b1;
          if (cur_rw == int'(WT)) bus_mem[cur_addr] = 16'(cur_data);
          phase = 3;
        end
      end
    end
  end

  // Line-level cache model.
  bit          m_valid [16];
  bit          m_dirty [16];
  int          m_tag   [16];
  logic [15:0] m_data  [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_op(input int rw, input int addr, input logic [15:0] wdata,
                          output logic [15:0] exp_rdata, output int exp_lat);
    int idx, tag, vaddr;
    idx       = addr % 16;
    tag       = addr / 16;
    exp_rdata = '0;
    exp_rw.delete();
    exp_addr.delete();
    exp_data.delete();
    if (m_valid[idx] && m_tag[idx] == tag) begin
      exp_lat = 1;
      if (rw == int'(RD)) exp_rdata = m_data[idx];
      else begin
        m_data[idx]  = wdata;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vaddr = m_tag[idx] * 16 + idx;
        exp_rw.push_back(int'(WT));
        exp_addr.push_back(vaddr);
        exp_data.push_back(int'(m_data[idx]));
        ref_mem[vaddr] = m_data[idx];
        exp_lat = (rw == int'(RD)) ? 2 * busy + 5 : busy + 3;
      end else begin
        exp_lat = (rw == int'(RD)) ? busy + 3 : 1;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      if (rw == int'(RD)) begin
        exp_rw.push_back(int'(RD));
        exp_addr.push_back(addr);
        exp_data.push_back(0);
        exp_rdata    = ref_mem[addr];
        m_data[idx]  = ref_mem[addr];
        m_dirty[idx] = 1'b0;
      end else begin
        m_data[idx]  = wdata;
        m_dirty[idx] = 1'b1;
      end
    end
  endtask

  task automatic wait_ready(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      lat = i;
      if (cpuReady) break;
    end
    check_eq("ready_wait", cpuReady, 1'b1);
  endtask

  task automatic check_txns();
    check_eq("txn_count", log_rw.size(), exp_rw.size());
    for (int i = 0; i < exp_rw.size() && i < log_rw.size(); i++) begin
      check_eq("txn_rw", log_rw[i], exp_rw[i]);
      check_eq("txn_addr", log_addr[i], exp_addr[i]);
      if (exp_rw[i] == int'(WT)) check_eq("txn_data", log_data[i], exp_data[i]);
    end
  endtask

  task automatic do_op(input int rw, input int addr, input logic [15:0] wdata);
    logic [15:0] exp_rdata;
    int exp_lat, lat;
    model_op(rw, addr, wdata, exp_rdata, exp_lat);
    log_rw.delete();
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
    cpuRw    = 2'(rw);
    cpuAddr  = 16'(addr);
    cpuWdata = wdata;
    wait_ready(4000, lat);
    if (rw == int'(RD)) check_eq("rdata", cpuRdata, exp_rdata);
    check_eq("latency", lat, exp_lat);
    cpuRw = IDEL;
    check_txns();
    @(negedge clk);
    check_eq("ready_pulse", cpuReady, 1'b0);
  endtask

  initial begin
    int lat;
    reset    = 1'b0;
    cpuRw    = IDEL;
    cpuAddr  = '0;
    cpuWdata = '0;
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 16'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[16'h0012] = 16'hBEEF;
    ref_mem[16'h0012] = 16'hBEEF;
    model_reset();

    repeat (3) @(negedge clk);
    check_eq("rst_rw", rwToBus, IDEL);
    check_eq("rst_addr", addrToBus, 0);
    check_eq("rst_data", dataToBus, 0);
    check_eq("rst_rdata", cpuRdata, 0);
    check_eq("rst_ready", cpuReady, 0);
    check_eq("rst_err", errReg, ERR_NONE);
    reset = 1'b1;

    // Directed scenarios.
    busy = 100;
    do_op(int'(RD), 16'h0012, 16'h0);
    do_op(int'(RD), 16'h0012, 16'h0);
    do_op(int'(WT), 16'h0012, 16'h1234);
    do_op(int'(RD), 16'h0022, 16'h0);
    do_op(int'(WT), 16'h0005, 16'h00AA);
    do_op(int'(RD), 16'h0005, 16'h0);
    busy = 300;
    do_op(int'(RD), 16'h0033, 16'h0);
    check_eq("err_after_long_busy", errReg, ERR_NONE);

    // Randomized traffic over a few tags so lines conflict and evict.
    for (int n = 0; n < 300; n++) begin
      busy = int'($urandom_range(1, 4));
      do_op(($urandom_range(0, 1) == 0) ? int'(RD) : int'(WT),
            int'($urandom_range(0, 3) * 16 + $urandom_range(0, 15)), 16'($urandom));
    end
    check_eq("err_after_random", errReg, ERR_NONE);

    // Reset while a bus transaction is open.
    busy = 100;
    @(negedge clk);
    cpuRw   = RD;
    cpuAddr = 16'h0077;
    repeat (10) @(negedge clk);
    check_eq("txn_open", rwToBus != IDEL, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("midrst_rw", rwToBus, IDEL);
    check_eq("midrst_ready", cpuReady, 1'b0);
    cpuRw = IDEL;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_op(int'(RD), 16'h0077, 16'h0);

    // Bus never goes busy: the fill must time out.
    pre_delay = 1100;
    log_rw.delete();
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
    cpuRw   = RD;
    cpuAddr = 16'h0040;
    wait_ready(3000, lat);
    check_eq("to_err", errReg, ERR_TIMEOUT);
    check_eq("to_rdata", cpuRdata, 0);
    check_eq("to_rw", rwToBus, IDEL);
    check_eq("to_txn_count", log_rw.size(), 1);
    cpuRw = IDEL;
    pre_delay = 1;
    @(negedge clk);
    do_op(int'(RD), 16'h0040, 16'h0);
    check_eq("to_sticky", errReg, ERR_TIMEOUT);

    // Illegal request encoding.
    log_rw.delete();
    @(negedge clk);
    cpuRw = 2'b11;
    wait_ready(10, lat);
    check_eq("badrw_lat", lat, 1);
    check_eq("badrw_err", errReg, ERR_BADRW);
    check_eq("badrw_rdata", cpuRdata, 0);
    check_eq("badrw_txn", log_rw.size(), 0);
    cpuRw = IDEL;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
